nios_mul_result_assembler: RTL



---
 rtl/nios_mul_result_assembler_pkg.sv | 24 ++
 rtl/nios_mul_sign_fix.sv | 29 ++
 rtl/nios_mul_result_assembler.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/nios_mul_result_assembler_pkg.sv
// Shared types and constants for the Nios II multiply result assembler.
// Op encodings, FSM state enum and the supported half-operand width.
package nios_mul_result_assembler_pkg;

   localparam int HALF_W = 16;

   localparam logic [1:0] MUL_OP_MUL    = 2'b00;
   localparam logic [1:0] MUL_OP_MULXUU = 2'b01;
   localparam logic [1:0] MUL_OP_MULXSU = 2'b10;
   localparam logic [1:0] MUL_OP_MULXSS = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PASS1,
      S_PASS2,
      S_FIX,
      S_DONE
   } mul_state_e;

   function automatic logic is_signed_op(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/nios_mul_sign_fix.sv
// Signed correction of the unsigned high product word for MULXSU/MULXSS.
// Instantiated only when MUL_SIGNED_HI_EN is defined.
module nios_mul_sign_fix #(
   parameter int W = 32
) (
   input  logic [W-1:0] hi_u,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [1:0]   op,
   output logic [W-1:0] hi_fix
);
   import nios_mul_result_assembler_pkg::*;

   logic [W-1:0] corr_a;
   logic [W-1:0] corr_b;

   assign corr_a = a[W-1] ? b : '0;
   assign corr_b = b[W-1] ? a : '0;

   always_comb begin
      hi_fix = hi_u;
      unique case (op)
         MUL_OP_MULXSU: hi_fix = hi_u - corr_a;
         MUL_OP_MULXSS: hi_fix = hi_u - corr_a - corr_b;
         default:       hi_fix = hi_u;
      endcase
   end

endmodule

// File: rtl/nios_mul_result_assembler.sv
// Assembles MUL/MULX* results from the 16x16 partial-product cell outputs.
// Define MUL_SIGNED_HI_EN to enable MULXSU/MULXSS sign correction.
module nios_mul_result_assembler #(
   parameter int HALF_W     = 16,
   parameter int PP_TIMEOUT = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [1:0]          op,
   input  logic [2*HALF_W-1:0] src1,
   input  logic [2*HALF_W-1:0] src2,
   input  logic                flush,
   input  logic                pp_valid,
   input  logic [2*HALF_W-1:0] p1,
   input  logic [2*HALF_W-1:0] p2,
   input  logic [2*HALF_W-1:0] p3,
   output logic                half_sel,
   output logic                busy,
   output logic [2*HALF_W-1:0] result,
   output logic                result_valid,
   output logic                err
);
   import nios_mul_result_assembler_pkg::*;

   localparam int W  = 2 * HALF_W;
   localparam int AW = W + HALF_W + 2;
   localparam int CW = $clog2(PP_TIMEOUT + 1);

`ifdef MUL_SIGNED_HI_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif

   mul_state_e        st;
   logic [1:0]        op_q;
   logic [CW-1:0]     cnt;
   logic [AW-W-1:0]   acc_hi;
   logic [W-1:0]      hi_u_q;
   logic [W-1:0]      res_q;
   logic [W-1:0]      hi_fix;
   logic [W:0]        mid;
   logic [AW-1:0]     acc;
   logic [W-1:0]      hi_u;

   // mid sum keeps its carry so the 50-bit accumulator never truncates
   assign mid  = {1'b0, p2} + {1'b0, p3};
   assign acc  = {{(AW-W){1'b0}}, p1} + {1'b0, mid, {HALF_W{1'b0}}};
   assign hi_u = {{(W-(AW-W)){1'b0}}, acc_hi} + p1;

`ifdef MUL_SIGNED_HI_EN
   logic [W-1:0] a_q;
   logic [W-1:0] b_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q <= '0;
         b_q <= '0;
      end else if (st == S_IDLE && start && !flush) begin
         a_q <= src1;
         b_q <= src2;
      end
   end

   nios_mul_sign_fix #(
      .W (W)
   ) u_sign_fix (
      .hi_u   (hi_u_q),
      .a      (a_q),
      .b      (b_q),
      .op     (op_q),
      .hi_fix (hi_fix)
   );
`else
   logic unused_ops;
   assign unused_ops = ^{src1, src2};
   assign hi_fix     = hi_u_q;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st           <= S_IDLE;
         op_q         <= '0;
         cnt          <= '0;
         acc_hi       <= '0;
         hi_u_q       <= '0;
         res_q        <= '0;
         half_sel     <= 1'b0;
         busy         <= 1'b0;
         result       <= '0;
         result_valid <= 1'b0;
         err          <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         err          <= 1'b0;
         if (flush && st != S_IDLE) begin
            st       <= S_IDLE;
            busy     <= 1'b0;
            half_sel <= 1'b0;
         end else begin
            unique case (st)
               S_IDLE: begin
                  if (start && !flush) begin
                     op_q <= op;
                     cnt  <= '0;
                     if (!SIGNED_EN && is_signed_op(op)) begin
                        err <= 1'b1;
                     end else begin
                        busy <= 1'b1;
                        st   <= S_PASS1;
                     end
                  end
               end
               S_PASS1: begin
                  if (pp_valid) begin
                     cnt <= '0;
                     if (op_q == MUL_OP_MUL) begin
                        res_q <= acc[W-1:0];
                        st    <= S_DONE;
                     end else begin
                        acc_hi   <= acc[AW-1:W];
                        half_sel <= 1'b1;
                        st       <= S_PASS2;
                     end
                  end else if (cnt == CW'(PP_TIMEOUT - 1)) begin
                     err  <= 1'b1;
                     busy <= 1'b0;
                     st   <= S_IDLE;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               S_PASS2: begin
                  if (pp_valid) begin
                     hi_u_q   <= hi_u;
                     half_sel <= 1'b0;
                     st       <= S_FIX;
                  end else if (cnt == CW'(PP_TIMEOUT - 1)) begin
                     err      <= 1'b1;
                     busy     <= 1'b0;
                     half_sel <= 1'b0;
                     st       <= S_IDLE;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               S_FIX: begin
                  res_q <= hi_fix;
                  st    <= S_DONE;
               end
               S_DONE: begin
                  result       <= res_q;
                  result_valid <= 1'b1;
                  busy         <= 1'b0;
                  half_sel     <= 1'b0;
                  st           <= S_IDLE;
               end
               default: st <= S_IDLE;
            endcase
         end
      end
   end

endmodule
